e_mdu: RTL and testbench

//  Multi-cycle multiply/divide unit in the E stage, beside the single-cycle ALU.

---
 rtl/e_mdu_pkg.sv | 30 +++
 rtl/e_mdu_if.sv | 18 +
 rtl/e_mdu.sv | 110 +++++++++++
 tb/tb_e_mdu.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: opcodes, FSM states
// and the opcode-class helper used by the MDU and the hazard logic.
package e_mdu_pkg;

  localparam int MDU_OP_W = 4;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for several cycles; codes 9-15 fall through as none.
  function automatic logic is_md_op(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Request/response bundle between the E stage (master) and the MDU (slave).
// en qualifies MDUOp/A/B for the cycle; busy/stall/HI/LO/C reflect the MDU.
interface e_mdu_if;
  import e_mdu_pkg::*;

  logic                en;
  logic [MDU_OP_W-1:0] MDUOp;
  logic [31:0]         A;
  logic [31:0]         B;
  logic                busy;
  logic                stall;
  logic [31:0]         HI;
  logic [31:0]         LO;
  logic [31:0]         C;

  modport master (output en, MDUOp, A, B, input busy, stall, HI, LO, C);
  modport slave  (input en, MDUOp, A, B, output busy, stall, HI, LO, C);
endinterface

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit: result is computed at issue, held in pending
// registers, and committed to HI/LO after a fixed busy window.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  e_mdu_if.slave     mdu,
  output mdu_state_e state_o
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  mdu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   hi_n_q, hi_n_d, lo_n_q, lo_n_d;

  logic          mul_signed, div_signed;
  logic [63:0]   a_ext, b_ext, prod;
  logic [31:0]   a_mag, b_mag, q_mag, r_mag, quot, rem;

  // Signed divide works on magnitudes so INT_MIN / -1 wraps to INT_MIN without a trap.
  always_comb begin
    mul_signed = (mdu.MDUOp == MDU_MULT);
    div_signed = (mdu.MDUOp == MDU_DIV);
    a_ext = {{32{mul_signed & mdu.A[31]}}, mdu.A};
    b_ext = {{32{mul_signed & mdu.B[31]}}, mdu.B};
    prod  = a_ext * b_ext;
    a_mag = (div_signed & mdu.A[31]) ? -mdu.A : mdu.A;
    b_mag = (div_signed & mdu.B[31]) ? -mdu.B : mdu.B;
    q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
    r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
    quot  = (div_signed & (mdu.A[31] ^ mdu.B[31])) ? -q_mag : q_mag;
    rem   = (div_signed & mdu.A[31]) ? -r_mag : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_n_d  = hi_n_q;
    lo_n_d  = lo_n_q;
    case (state_q)
      ST_IDLE: begin
        if (mdu.en) begin
          case (mdu.MDUOp)
            MDU_MULT, MDU_MULTU: begin
              hi_n_d  = prod[63:32];
              lo_n_d  = prod[31:0];
              cnt_d   = CW'(MULT_CYCLES);
              state_d = ST_BUSY;
            end
            MDU_DIV, MDU_DIVU: begin
              // Divide by zero commits the current HI/LO, i.e. leaves them unchanged.
              hi_n_d  = (mdu.B == 32'd0) ? hi_q : rem;
              lo_n_d  = (mdu.B == 32'd0) ? lo_q : quot;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = ST_BUSY;
            end
            MDU_MTHI: hi_d = mdu.A;
            MDU_MTLO: lo_d = mdu.A;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          hi_d    = hi_n_q;
          lo_d    = lo_n_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_n_q  <= '0;
      lo_n_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_n_q  <= hi_n_d;
      lo_n_q  <= lo_n_d;
    end
  end

  assign mdu.busy  = (state_q == ST_BUSY);
  assign mdu.stall = mdu.busy | (mdu.en & is_md_op(mdu.MDUOp));
  assign mdu.HI    = hi_q;
  assign mdu.LO    = lo_q;
  assign mdu.C     = (mdu.MDUOp == MDU_MFHI) ? hi_q :
                     (mdu.MDUOp == MDU_MFLO) ? lo_q : 32'd0;
  assign state_o   = state_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: reset abort, mult/div arithmetic and boundaries,
// busy window length, stall/C behaviour during busy, and ignored requests.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  mdu_state_e st;
  int         n_cmp = 0;
  int         n_bad = 0;

  e_mdu_if bus ();

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .mdu     (bus),
    .state_o (st)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic e, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.en    = e;
    bus.MDUOp = op;
    bus.A     = a;
    bus.B     = b;
    #1;
  endtask

  task automatic idle_inputs();
    drive(1'b0, MDU_NONE, 32'd0, 32'd0);
  endtask

  task automatic write_hilo(input logic [31:0] hi, input logic [31:0] lo);
    drive(1'b1, MDU_MTHI, hi, 32'd0);
    tick();
    drive(1'b1, MDU_MTLO, lo, 32'd0);
    tick();
    idle_inputs();
  endtask

  // Issue one mult/div, measure the busy window, then check the committed HI/LO.
  task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cnt;
    drive(1'b1, op, a, b);
    check_eq({tag, "_busy_pre"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_stall_pre"}, 32'(bus.stall), 32'd1);
    tick();
    idle_inputs();
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
    check_eq({tag, "_busy_len"}, 32'(cnt), 32'(n));
    check_eq({tag, "_hi"}, bus.HI, exp_hi);
    check_eq({tag, "_lo"}, bus.LO, exp_lo);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #12;
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_hi", bus.HI, 32'd0);
    check_eq("rst_lo", bus.LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset in the middle of a mult: aborts it and clears HI/LO at once.
    write_hilo(32'h0000_AAAA, 32'h0000_BBBB);
    check_eq("mthi_hi", bus.HI, 32'h0000_AAAA);
    check_eq("mtlo_lo", bus.LO, 32'h0000_BBBB);
    drive(1'b1, MDU_MULT, 32'd9, 32'd9);
    tick();
    idle_inputs();
    tick();
    reset = 1'b1;
    #1;
    check_eq("rstmid_busy", 32'(bus.busy), 32'd0);
    check_eq("rstmid_state", 32'(st), 32'(ST_IDLE));
    check_eq("rstmid_hi", bus.HI, 32'd0);
    check_eq("rstmid_lo", bus.LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) tick();
    drive(1'b0, MDU_MFLO, 32'd0, 32'd0);
    check_eq("rstmid_mflo_c", bus.C, 32'd0);
    check_eq("rstmid_busy_late", 32'(bus.busy), 32'd0);
    idle_inputs();

    run_md("mult",  MDU_MULT,  32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_md("multu", MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);

    // Back-to-back: second op issued in the first cycle after the first completes.
    run_md("b2b_mult", MDU_MULT, 32'h10, 32'h10, 5, 32'd0, 32'h100);
    run_md("b2b_div",  MDU_DIV,  32'd100, 32'd7, 10, 32'd2, 32'd14);

    run_md("div_neg",  MDU_DIV,  32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu",     MDU_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_md("div_negb", MDU_DIV,  32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
    run_md("div_ovf",  MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

    write_hilo(32'h1234, 32'h5678);
    run_md("divu_z", MDU_DIVU, 32'd5, 32'd0, 10, 32'h1234, 32'h5678);
    run_md("div_z",  MDU_DIV,  32'hFFFF_FFF0, 32'd0, 10, 32'h1234, 32'h5678);

    // mflo held in E while the mult is in flight: stalled, old LO until commit.
    drive(1'b1, MDU_MULT, 32'd6, 32'd7);
    tick();
    drive(1'b1, MDU_MFLO, 32'd0, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      check_eq($sformatf("mflo_busy_stall_%0d", k), 32'(bus.stall), 32'd1);
      check_eq($sformatf("mflo_busy_c_%0d", k), bus.C, 32'h5678);
      tick();
    end
    check_eq("mflo_done_stall", 32'(bus.stall), 32'd0);
    check_eq("mflo_done_c", bus.C, 32'd42);
    drive(1'b0, MDU_MFHI, 32'd0, 32'd0);
    check_eq("mfhi_c", bus.C, 32'd0);

    // mthi offered while busy must be ignored.
    drive(1'b1, MDU_MULTU, 32'd2, 32'd3);
    tick();
    drive(1'b1, MDU_MTHI, 32'hDEAD, 32'd0);
    repeat (5) tick();
    idle_inputs();
    check_eq("mthi_busy_hi", bus.HI, 32'd0);
    check_eq("mthi_busy_lo", bus.LO, 32'd6);

    // Without en nothing starts, whatever MDUOp says.
    drive(1'b0, MDU_MULT, 32'd5, 32'd5);
    check_eq("noen_stall", 32'(bus.stall), 32'd0);
    tick();
    check_eq("noen_busy", 32'(bus.busy), 32'd0);
    drive(1'b0, MDU_MTLO, 32'hFFFF, 32'd0);
    tick();
    check_eq("noen_lo", bus.LO, 32'd6);

    // Undefined opcode behaves as none.
    drive(1'b1, 4'd9, 32'd5, 32'd5);
    check_eq("op9_stall", 32'(bus.stall), 32'd0);
    check_eq("op9_c", bus.C, 32'd0);
    tick();
    check_eq("op9_busy", 32'(bus.busy), 32'd0);
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
